// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit and its helpers.
//   SIZE_*         access size encodings driven to RAM256x8 Size
//   lsu_state_e    sequencer states
//   is_misaligned  alignment rule for a (size, low address bits) pair
package lsu_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } lsu_state_e;

  // Only the two low address bits matter for alignment; size 11 is always a fault.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    case (size)
      SIZE_BYTE: mis = 1'b0;
      SIZE_HALF: mis = addr_lo[0];
      SIZE_WORD: mis = (addr_lo != 2'b00);
      default:   mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Combinational load-data extender.
//   size      in  2   SIZE_BYTE / SIZE_HALF / SIZE_WORD
//   sign_ext  in  1   1 replicate the field's top bit, 0 zero-fill
//   raw       in  32  right-justified data from the RAM
//   ext       out 32  extended result
module lsu_load_extend
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] raw,
  output logic [31:0] ext
);

  always_comb begin
    case (size)
      SIZE_BYTE: ext = {{24{sign_ext & raw[7]}}, raw[7:0]};
      SIZE_HALF: ext = {{16{sign_ext & raw[15]}}, raw[15:0]};
      default:   ext = raw;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store sequencer in front of RAM256x8.
//   clk, reset                       clock, asynchronous active-high reset
//   req_valid/req_ready              request handshake (accepted only in IDLE)
//   req_write/size/signed/addr/wdata request fields, sampled at the handshake
//   resp_valid/rdata/misalign        one-cycle response
//   mem_enable/rw/addr/size/wdata    registered RAM controls
//   mem_rdata                        RAM read data
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [7:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_misalign,
  output logic        mem_enable,
  output logic        mem_rw,
  output logic [7:0]  mem_addr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  lsu_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        sgn_q, sgn_d;
  logic        misalign_q, misalign_d;
  logic [31:0] rdata_q, rdata_d;
  logic        mem_enable_q, mem_enable_d;
  logic        mem_rw_q, mem_rw_d;
  logic [7:0]  mem_addr_q, mem_addr_d;
  logic [1:0]  mem_size_q, mem_size_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] ext_data;
  logic        req_mis;

  assign req_mis = is_misaligned(req_size, req_addr[1:0]);

  lsu_load_extend u_extend (
    .size     (mem_size_q),
    .sign_ext (sgn_q),
    .raw      (mem_rdata),
    .ext      (ext_data)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (req_valid) state_d = req_mis ? ST_RESP : ST_ACCESS;
      ST_ACCESS: if (cnt_q == 4'd0) state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    req_ready  = (state_q == ST_IDLE);
    resp_valid = (state_q == ST_RESP);
  end

  // Datapath next values
  always_comb begin
    cnt_d        = cnt_q;
    sgn_d        = sgn_q;
    misalign_d   = misalign_q;
    rdata_d      = rdata_q;
    mem_enable_d = mem_enable_q;
    mem_rw_d     = mem_rw_q;
    mem_addr_d   = mem_addr_q;
    mem_size_d   = mem_size_q;
    mem_wdata_d  = mem_wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          sgn_d      = req_signed;
          misalign_d = req_mis;
          rdata_d    = 32'd0;
          // A faulting request leaves the RAM bus untouched.
          if (!req_mis) begin
            mem_enable_d = 1'b1;
            mem_rw_d     = req_write;
            mem_addr_d   = req_addr;
            mem_size_d   = req_size;
            mem_wdata_d  = req_wdata;
            cnt_d        = WAIT_INIT;
          end
        end
      end
      ST_ACCESS: begin
        if (cnt_q == 4'd0) begin
          mem_enable_d = 1'b0;
          if (!mem_rw_q) rdata_d = ext_data;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q        <= 4'd0;
      sgn_q        <= 1'b0;
      misalign_q   <= 1'b0;
      rdata_q      <= 32'd0;
      mem_enable_q <= 1'b0;
      mem_rw_q     <= 1'b0;
      mem_addr_q   <= 8'd0;
      mem_size_q   <= 2'd0;
      mem_wdata_q  <= 32'd0;
    end else begin
      cnt_q        <= cnt_d;
      sgn_q        <= sgn_d;
      misalign_q   <= misalign_d;
      rdata_q      <= rdata_d;
      mem_enable_q <= mem_enable_d;
      mem_rw_q     <= mem_rw_d;
      mem_addr_q   <= mem_addr_d;
      mem_size_q   <= mem_size_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign resp_rdata    = rdata_q;
  assign resp_misalign = misalign_q;
  assign mem_enable    = mem_enable_q;
  assign mem_rw        = mem_rw_q;
  assign mem_addr      = mem_addr_q;
  assign mem_size      = mem_size_q;
  assign mem_wdata     = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: two instances (WAIT_CYCLES 0 and 3), each with its
// own big-endian RAM256x8 model, checked against a byte-array reference memory.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic reset;
  logic ram_clear;

  logic        req_valid[2], req_ready[2], req_write[2], req_signed[2];
  logic [1:0]  req_size[2];
  logic [7:0]  req_addr[2];
  logic [31:0] req_wdata[2];
  logic        resp_valid[2], resp_misalign[2];
  logic [31:0] resp_rdata[2];
  logic        mem_enable[2], mem_rw[2];
  logic [7:0]  mem_addr[2];
  logic [1:0]  mem_size[2];
  logic [31:0] mem_wdata[2], mem_rdata[2];

  logic [7:0] ram[2][256];        // RAM256x8 contents, written by the DUTs
  logic [7:0] model_mem[2][256];  // reference memory, updated per transaction

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    load_store_unit #(.WAIT_CYCLES(g * 3)) u_dut (
      .clk           (clk),
      .reset         (reset),
      .req_valid     (req_valid[g]),
      .req_ready     (req_ready[g]),
      .req_write     (req_write[g]),
      .req_size      (req_size[g]),
      .req_signed    (req_signed[g]),
      .req_addr      (req_addr[g]),
      .req_wdata     (req_wdata[g]),
      .resp_valid    (resp_valid[g]),
      .resp_rdata    (resp_rdata[g]),
      .resp_misalign (resp_misalign[g]),
      .mem_enable    (mem_enable[g]),
      .mem_rw        (mem_rw[g]),
      .mem_addr      (mem_addr[g]),
      .mem_size      (mem_size[g]),
      .mem_wdata     (mem_wdata[g]),
      .mem_rdata     (mem_rdata[g])
    );
  end

  // RAM model: synchronous big-endian write, combinational right-justified read.
  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (ram_clear) begin
        for (int i = 0; i < 256; i++) ram[u][i] <= 8'h00;
      end else if (mem_enable[u] && mem_rw[u]) begin
        case (mem_size[u])
          2'b00: ram[u][mem_addr[u]] <= mem_wdata[u][7:0];
          2'b01: begin
            ram[u][mem_addr[u]]         <= mem_wdata[u][15:8];
            ram[u][mem_addr[u] + 8'd1]  <= mem_wdata[u][7:0];
          end
          default: begin
            ram[u][mem_addr[u]]         <= mem_wdata[u][31:24];
            ram[u][mem_addr[u] + 8'd1]  <= mem_wdata[u][23:16];
            ram[u][mem_addr[u] + 8'd2]  <= mem_wdata[u][15:8];
            ram[u][mem_addr[u] + 8'd3]  <= mem_wdata[u][7:0];
          end
        endcase
      end
    end
  end

  always_comb begin
    for (int u = 0; u < 2; u++) begin
      mem_rdata[u] = 32'd0;
      if (mem_enable[u] && !mem_rw[u]) begin
        case (mem_size[u])
          2'b00:   mem_rdata[u] = {24'd0, ram[u][mem_addr[u]]};
          2'b01:   mem_rdata[u] = {16'd0, ram[u][mem_addr[u]], ram[u][mem_addr[u] + 8'd1]};
          default: mem_rdata[u] = {ram[u][mem_addr[u]], ram[u][mem_addr[u] + 8'd1],
                                   ram[u][mem_addr[u] + 8'd2], ram[u][mem_addr[u] + 8'd3]};
        endcase
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit model_mis(input logic [1:0] sz, input logic [7:0] a);
    if (sz == 2'd3) return 1'b1;
    if (sz == 2'd1) return (a % 2) != 0;
    if (sz == 2'd2) return (a % 4) != 0;
    return 1'b0;
  endfunction

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_load(input int u, input logic [1:0] sz,
                                             input bit sg, input logic [7:0] a);
    longint v = 0;
    int n = nbytes(sz);
    for (int i = 0; i < n; i++) v = v * 256 + longint'(model_mem[u][8'(a + i)]);
    if (sg && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  task automatic model_store(input int u, input logic [1:0] sz, input logic [7:0] a,
                             input logic [31:0] wd);
    int n = nbytes(sz);
    for (int i = 0; i < n; i++) model_mem[u][8'(a + i)] = 8'(wd >> (8 * (n - 1 - i)));
  endtask

  // One complete transaction with latency, bus-window and result checks.
  task automatic do_req(input int u, input bit wr, input logic [1:0] sz, input bit sg,
                        input logic [7:0] a, input logic [31:0] wd, input string tag);
    bit mis = model_mis(sz, a);
    int wc = (u == 0) ? 0 : 3;
    logic [31:0] exp_rd = (wr || mis) ? 32'd0 : model_load(u, sz, sg, a);
    int guard = 0;
    int lat = 0;
    int en_cnt = 0;
    bit unstable = 0;
    logic [42:0] bus0 = '0;
    logic [31:0] got_rd = 32'd0;
    logic got_mis = 1'b0;
    @(negedge clk);
    while (!req_ready[u] && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready[u]) begin
      chk({tag, "_ready_timeout"}, 32'd0, 32'd1);
      return;
    end
    req_valid[u] = 1'b1; req_write[u] = wr; req_size[u] = sz;
    req_signed[u] = sg; req_addr[u] = a; req_wdata[u] = wd;
    @(posedge clk);
    #1;
    // Post-handshake request fields are junk and must be ignored.
    req_valid[u] = 1'b0; req_write[u] = 1'($urandom); req_size[u] = 2'($urandom);
    req_signed[u] = 1'($urandom); req_addr[u] = 8'($urandom); req_wdata[u] = $urandom;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (mem_enable[u]) begin
        if (en_cnt == 0) bus0 = {mem_rw[u], mem_addr[u], mem_size[u], mem_wdata[u]};
        else if (bus0 != {mem_rw[u], mem_addr[u], mem_size[u], mem_wdata[u]}) unstable = 1;
        en_cnt++;
      end
      if (resp_valid[u]) begin
        lat = k; got_rd = resp_rdata[u]; got_mis = resp_misalign[u];
        break;
      end
    end
    chk({tag, "_latency"}, lat, mis ? 1 : 2 + wc);
    chk({tag, "_misalign"}, 32'(got_mis), 32'(mis));
    chk({tag, "_rdata"}, got_rd, exp_rd);
    chk({tag, "_en_cycles"}, en_cnt, mis ? 0 : wc + 1);
    chk({tag, "_bus_stable"}, 32'(unstable), 32'd0);
    if (!mis) begin
      chk({tag, "_bus_addr"}, 32'(bus0[41:34]), 32'(a));
      chk({tag, "_bus_rw_size"}, 32'({bus0[42], bus0[33:32]}), 32'({wr, sz}));
    end
    @(negedge clk);
    chk({tag, "_resp_one_cycle"}, 32'(resp_valid[u]), 32'd0);
    if (wr && !mis) model_store(u, sz, a, wd);
  endtask

  initial begin
    int acc_cyc[4];
    int n_acc, n_resp, rd_bad;
    logic [31:0] exp_w;
    reset = 1'b1;
    ram_clear = 1'b1;
    for (int u = 0; u < 2; u++) begin
      req_valid[u] = 0; req_write[u] = 0; req_size[u] = 0; req_signed[u] = 0;
      req_addr[u] = 0; req_wdata[u] = 0;
      for (int i = 0; i < 256; i++) model_mem[u][i] = 8'h00;
    end
    repeat (3) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      chk("rst_req_ready", 32'(req_ready[u]), 32'd1);
      chk("rst_resp_valid", 32'(resp_valid[u]), 32'd0);
      chk("rst_resp_rdata", resp_rdata[u], 32'd0);
      chk("rst_resp_misalign", 32'(resp_misalign[u]), 32'd0);
      chk("rst_mem_enable", 32'(mem_enable[u]), 32'd0);
      chk("rst_mem_rw", 32'(mem_rw[u]), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr[u]), 32'd0);
      chk("rst_mem_size", 32'(mem_size[u]), 32'd0);
      chk("rst_mem_wdata", mem_wdata[u], 32'd0);
    end
    reset = 1'b0;
    ram_clear = 1'b0;

    // Word store/load and RAM byte order
    do_req(0, 1, 2'b10, 0, 8'h10, 32'hDEADBEEF, "t1_store");
    chk("t1_ram10", 32'(ram[0][8'h10]), 32'hDE);
    chk("t1_ram11", 32'(ram[0][8'h11]), 32'hAD);
    chk("t1_ram12", 32'(ram[0][8'h12]), 32'hBE);
    chk("t1_ram13", 32'(ram[0][8'h13]), 32'hEF);
    do_req(0, 0, 2'b10, 0, 8'h10, 32'h0, "t1_load");
    chk("t1_model_word", model_load(0, 2'b10, 0, 8'h10), 32'hDEADBEEF);

    // Sub-word extension
    do_req(0, 0, 2'b00, 1, 8'h12, 32'h0, "t2_sbyte");
    chk("t2_model_sbyte", model_load(0, 2'b00, 1, 8'h12), 32'hFFFFFFBE);
    do_req(0, 0, 2'b01, 0, 8'h10, 32'h0, "t2_uhalf");
    chk("t2_model_uhalf", model_load(0, 2'b01, 0, 8'h10), 32'h0000DEAD);

    // Faults
    do_req(0, 0, 2'b01, 0, 8'h11, 32'h0, "t3_half_mis");
    do_req(0, 0, 2'b10, 1, 8'h22, 32'h0, "t3_word_mis");
    do_req(0, 1, 2'b11, 0, 8'h40, 32'h12345678, "t3_size11");

    // Stretched window on the WAIT_CYCLES=3 instance at the top address
    do_req(1, 1, 2'b00, 0, 8'hFF, 32'h0000005A, "t4_store");
    do_req(1, 0, 2'b00, 0, 8'hFF, 32'h0, "t4_load");
    chk("t4_ramFF", 32'(ram[1][8'hFF]), 32'h5A);

    // Back-to-back with req_valid held
    exp_w = model_load(0, 2'b10, 0, 8'h10);
    n_acc = 0; n_resp = 0; rd_bad = 0;
    @(negedge clk);
    req_valid[0] = 1; req_write[0] = 0; req_size[0] = 2'b10; req_signed[0] = 0;
    req_addr[0] = 8'h10;
    for (int c = 0; c < 24; c++) begin
      if (c > 0) @(negedge clk);
      if (resp_valid[0]) begin
        n_resp++;
        if (resp_rdata[0] !== exp_w) rd_bad++;
      end
      if (n_acc == 4) req_valid[0] = 0;
      else if (req_ready[0]) begin
        acc_cyc[n_acc] = c;
        n_acc++;
      end
    end
    chk("t5_accepts", n_acc, 4);
    for (int i = 0; i < 3; i++) chk("t5_spacing", acc_cyc[i + 1] - acc_cyc[i], 3);
    chk("t5_resp_count", n_resp, 4);
    chk("t5_resp_data_bad", rd_bad, 0);

    // Reset during ACCESS
    @(negedge clk);
    req_valid[0] = 1; req_write[0] = 0; req_size[0] = 2'b00; req_signed[0] = 1;
    req_addr[0] = 8'h12;
    @(posedge clk);
    #1;
    req_valid[0] = 0;
    chk("t6_en_before", 32'(mem_enable[0]), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("t6_en_dropped", 32'(mem_enable[0]), 32'd0);
    chk("t6_ready", 32'(req_ready[0]), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    n_resp = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (resp_valid[0]) n_resp++;
    end
    chk("t6_no_resp", n_resp, 0);
    do_req(0, 0, 2'b00, 1, 8'h12, 32'h0, "t6_after");

    // Randomized traffic on both instances
    for (int u = 0; u < 2; u++) begin
      for (int t = 0; t < 120; t++) begin
        int r = int'($urandom % 8);
        logic [1:0] sz = (r == 7) ? 2'b11 : 2'(r % 3);
        logic [7:0] a = 8'($urandom);
        if ($urandom % 4 != 0) begin
          if (sz == 2'b01) a[0] = 1'b0;
          if (sz == 2'b10) a[1:0] = 2'b00;
        end
        do_req(u, 1'($urandom), sz, 1'($urandom), a, $urandom, "rnd");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
